// File: rtl/square_color_ctrl.sv
// Colour/size control ahead of the VGA square renderer: debounced size buttons and a 6-phase hue ramp.
// Outputs change only at frame start. Define SIZE_WRAP_EN to make the size index wrap instead of saturate.
module square_color_ctrl #(
   parameter int CD              = 12,
   parameter int DB_CYCLES       = 2_000_000,
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [10:0]   hc,
   input  logic [10:0]   vc,
   input  logic          btn_up,
   input  logic          btn_dn,
   output logic [CD-1:0] color_rgb,
   output logic [3:0]    square_size
);

   localparam int             DBW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
   localparam logic [7:0]     FPS_LAST = 8'(FRAMES_PER_STEP - 1);

   typedef enum logic [2:0] {G_UP, R_DN, B_UP, G_DN, R_UP, B_DN} hue_t;

   // Bit 0 is the up button, bit 1 the down button.
   logic [1:0]     sync_a, sync_b, stable, stable_q, press;
   logic [DBW-1:0] db_cnt [2];

   logic [2:0]  pend_idx, pend_nxt;
   logic        zero_now, prev_zero, fs_pulse, step;
   logic [7:0]  frame_div;
   hue_t        state, state_nxt;
   logic [11:0] col_nxt;

   function automatic logic [3:0] ramp(input logic [3:0] ch, input logic up);
      if (up) return (ch == 4'hF) ? ch : ch + 4'd1;
      return (ch == 4'h0) ? ch : ch - 4'd1;
   endfunction

   function automatic logic [3:0] decode(input logic [2:0] idx);
      case (idx)
         3'd1:    return 4'b0001;
         3'd2:    return 4'b0010;
         3'd3:    return 4'b0100;
         3'd4:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // NOTE: the per-button counter array is reset explicitly, so no partial count survives a reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a   <= '0;
         sync_b   <= '0;
         stable   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync_a   <= {btn_dn, btn_up};
         sync_b   <= sync_a;
         stable_q <= stable;
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync_b[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press    = stable & ~stable_q;
   assign zero_now = (hc == '0) && (vc == '0);
   assign fs_pulse = zero_now && !prev_zero;
   assign step     = fs_pulse && (frame_div == FPS_LAST);

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      pend_nxt = pend_idx;
      if (press[0] && !press[1]) begin
`ifdef SIZE_WRAP_EN
         pend_nxt = (pend_idx == 3'd4) ? 3'd0 : pend_idx + 3'd1;
`else
         pend_nxt = (pend_idx == 3'd4) ? pend_idx : pend_idx + 3'd1;
`endif
      end else if (press[1] && !press[0]) begin
`ifdef SIZE_WRAP_EN
         pend_nxt = (pend_idx == 3'd0) ? 3'd4 : pend_idx - 3'd1;
`else
         pend_nxt = (pend_idx == 3'd0) ? pend_idx : pend_idx - 3'd1;
`endif
      end
   end

   // Hue wheel: each phase ramps one channel and hands over once that channel hits its end value.
   always_comb begin
      state_nxt = state;
      col_nxt   = color_rgb[11:0];
      if (step) begin
         case (state)
            G_UP: begin
               col_nxt[7:4] = ramp(color_rgb[7:4], 1'b1);
               if (col_nxt[7:4] == 4'hF) state_nxt = R_DN;
            end
            R_DN: begin
               col_nxt[11:8] = ramp(color_rgb[11:8], 1'b0);
               if (col_nxt[11:8] == 4'h0) state_nxt = B_UP;
            end
            B_UP: begin
               col_nxt[3:0] = ramp(color_rgb[3:0], 1'b1);
               if (col_nxt[3:0] == 4'hF) state_nxt = G_DN;
            end
            G_DN: begin
               col_nxt[7:4] = ramp(color_rgb[7:4], 1'b0);
               if (col_nxt[7:4] == 4'h0) state_nxt = R_UP;
            end
            R_UP: begin
               col_nxt[11:8] = ramp(color_rgb[11:8], 1'b1);
               if (col_nxt[11:8] == 4'hF) state_nxt = B_DN;
            end
            B_DN: begin
               col_nxt[3:0] = ramp(color_rgb[3:0], 1'b0);
               if (col_nxt[3:0] == 4'h0) state_nxt = G_UP;
            end
            default: state_nxt = G_UP;
         endcase
      end
   end

   // prev_zero resets high so a frame already at 0,0 when reset releases is not taken as a start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= G_UP;
         color_rgb   <= 12'hF00;
         square_size <= 4'b0001;
         frame_div   <= '0;
         pend_idx    <= 3'd1;
         prev_zero   <= 1'b1;
      end else begin
         prev_zero <= zero_now;
         pend_idx  <= pend_nxt;
         state     <= state_nxt;
         color_rgb <= col_nxt;
         if (fs_pulse) begin
            square_size <= decode(pend_idx);
            frame_div   <= (frame_div == FPS_LAST) ? '0 : frame_div + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_square_color_ctrl.sv
// Scoreboard bench for square_color_ctrl: stimulus queues per-frame expectations, a monitor checks at each commit.
// Uses a shrunken 8x4 frame so a full hue cycle fits in a short run.
module tb_square_color_ctrl;

   localparam int DB_CYCLES = 4;
   localparam int FPS       = 1;
   localparam int H_TOTAL   = 8;
   localparam int V_TOTAL   = 4;
   localparam int FRAME_CLK = H_TOTAL * V_TOTAL * 4;

   typedef struct packed {
      int          frame;
      logic [11:0] color;
      logic [3:0]  size;
   } exp_t;

`ifdef SIZE_WRAP_EN
   localparam logic [3:0] SZ_SEQ [13] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                          4'b0001, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
`else
   localparam logic [3:0] SZ_SEQ [13] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000,
                                          4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
`endif
   localparam int          HUE_F [10] = '{15, 16, 30, 45, 60, 75, 89, 90, 91, 97};
   localparam logic [11:0] HUE_C [10] = '{12'hFF0, 12'hEF0, 12'h0F0, 12'h0FF, 12'h00F,
                                          12'hF0F, 12'hF01, 12'hF00, 12'hF10, 12'hF70};

   logic        clk     = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] hc      = 11'd1;
   logic [10:0] vc      = 11'd0;
   logic        btn_up  = 1'b0;
   logic        btn_dn  = 1'b0;
   logic [11:0] color_rgb;
   logic [3:0]  square_size;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   frame_no = 0;
   bit   mid_change    = 1'b0;
   bit   commit_window = 1'b0;
   exp_t sb [$];

   square_color_ctrl #(
      .CD(12), .DB_CYCLES(DB_CYCLES), .FRAMES_PER_STEP(FPS)
   ) dut (
      .clk(clk), .reset_n(reset_n), .hc(hc), .vc(vc), .btn_up(btn_up), .btn_dn(btn_dn),
      .color_rgb(color_rgb), .square_size(square_size)
   );

   always #5 clk = ~clk;

   // Sync-stage stand-in: hc/vc advance every 4 clk.
   initial forever begin
      repeat (4) @(posedge clk);
      #1;
      if (hc == 11'(H_TOTAL - 1)) begin
         hc = '0;
         vc = (vc == 11'(V_TOTAL - 1)) ? '0 : vc + 11'd1;
      end else begin
         hc = hc + 11'd1;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int frame, input logic [11:0] color, input logic [3:0] size);
      exp_t e;
      e.frame = frame;
      e.color = color;
      e.size  = size;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0 && sb[0].frame == frame_no) begin
         e = sb.pop_front();
         check($sformatf("color_f%0d", e.frame), 16'(color_rgb), 16'(e.color));
         check($sformatf("size_f%0d", e.frame), 16'(square_size), 16'(e.size));
      end
   endtask

   // Monitor: commits are the clk after the bench-visible frame start.
   initial begin
      bit zero, prev_zero, rst_seen;
      prev_zero = 1'b0;
      rst_seen  = 1'b0;
      forever begin
         @(posedge clk);
         zero = (hc == '0) && (vc == '0);
         if (!reset_n) begin
            frame_no  = 0;
            rst_seen  = 1'b0;
            prev_zero = zero;
         end else if (!rst_seen) begin
            rst_seen  = 1'b1;
            prev_zero = zero;
            #2;
            drain();
         end else if (zero && !prev_zero) begin
            prev_zero     = zero;
            commit_window = 1'b1;
            #2;
            frame_no++;
            check($sformatf("stable_before_f%0d", frame_no), 16'(mid_change), 16'd0);
            mid_change = 1'b0;
            drain();
            commit_window = 1'b0;
         end else begin
            prev_zero = zero;
         end
      end
   end

   always @(color_rgb or square_size)
      if (reset_n && !commit_window) mid_change = 1'b1;

   always @(negedge reset_n) begin
      exp_t e;
      #1;
      frame_no   = 0;
      mid_change = 1'b0;
      if (sb.size() > 0 && sb[0].frame == -1) begin
         e = sb.pop_front();
         check("color_async_reset", 16'(color_rgb), 16'(e.color));
         check("size_async_reset", 16'(square_size), 16'(e.size));
      end
   end

   task automatic wait_frame(input int n);
      int budget, t;
      budget = (n - frame_no + 1) * (FRAME_CLK + 8);
      t = 0;
      while (frame_no < n && t < budget) begin
         @(posedge clk);
         t++;
      end
      check($sformatf("reach_frame_%0d", n), 16'(frame_no), 16'(n));
   endtask

   task automatic release_reset();
      int guard;
      guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (!(hc >= 11'd2 && hc <= 11'd5) && guard < 100);
      #3 reset_n = 1'b1;
   endtask

   task automatic press(input logic up, input logic dn);
      @(posedge clk);
      #1;
      btn_up = up;
      btn_dn = dn;
      repeat (10) @(posedge clk);
      #1;
      btn_up = 1'b0;
      btn_dn = 1'b0;
   endtask

   initial begin
      repeat (5) @(posedge clk);
      push(0, 12'hF00, SZ_SEQ[0]);
      release_reset();

      // 3-clk glitch is shorter than the debounce window.
      @(posedge clk);
      #1 btn_up = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_up = 1'b0;
      push(1, 12'hF10, SZ_SEQ[1]);
      wait_frame(1);

      for (int f = 1; f <= 11; f++) begin
         push(f + 1, 12'hF00 | 12'((f + 1) << 4), SZ_SEQ[f + 1]);
         if (f <= 5)       press(1'b1, 1'b0);
         else if (f <= 10) press(1'b0, 1'b1);
         else              press(1'b1, 1'b1);
         wait_frame(f + 1);
      end

      for (int i = 0; i < 10; i++) push(HUE_F[i], HUE_C[i], SZ_SEQ[12]);
      wait_frame(97);

      // Reset mid-ramp with the button mid-debounce, then keep it held briefly past release.
      @(posedge clk);
      #1 btn_up = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      push(-1, 12'hF00, 4'b0001);
      reset_n = 1'b0;
      repeat (20) @(posedge clk);
      push(0, 12'hF00, 4'b0001);
      release_reset();
      repeat (2) @(posedge clk);
      #1 btn_up = 1'b0;
      push(1, 12'hF10, 4'b0001);
      wait_frame(1);
      push(2, 12'hF20, 4'b0010);
      press(1'b1, 1'b0);
      wait_frame(2);

      repeat (5) @(posedge clk);
      check("scoreboard_left", 16'(sb.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
